// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared digit width and select-polarity helper for the seven-segment scanner.
package sev_seg_pkg;
  localparam int DIGIT_W = 4;
  function automatic logic [31:0] sel_off(input logic active_low);
    return active_low ? '1 : '0;
  endfunction
endpackage

// File: rtl/sev_seg_prescaler.sv
// sev_seg_prescaler: free-running slot counter with a tick on its last count.
module sev_seg_prescaler #(
  parameter int REFRESH_DIV = 50000,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          tick
);
  localparam logic [CW-1:0] TOP = CW'(REFRESH_DIV - 1);
  assign tick = cnt == TOP;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/sev_seg_scanner.sv
// sev_seg_scanner: double-buffered multiplexed seven-segment scan with blanking and dead cycles.
module sev_seg_scanner
  import sev_seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW_SELECT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dots_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  blank_leading,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  dot,
  output logic [DIGITS-1:0]     select,
  output logic                  pending,
  output logic                  frame_done
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF = DIGITS'(sel_off(ACTIVE_LOW_SELECT != 0));
  logic [CW-1:0] cnt;
  logic tick, boundary, nz;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] shadow, disp;
  logic [DIGITS-1:0] shadow_dots, disp_dots, blanked, onehot;
  sev_seg_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_pre (.clk(clk), .rst(rst), .cnt(cnt), .tick(tick));
  assign boundary = tick && idx == LAST;
  assign onehot = DIGITS'(1) << idx;
  // Walk down from the top digit: a digit is blank while nothing above or at it is nonzero.
  always_comb begin
    blanked = '0;
    nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz = nz | (disp[DIGIT_W*i +: DIGIT_W] != '0);
      blanked[i] = blank_leading & ~nz;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      shadow <= '0;
      shadow_dots <= '0;
      disp <= '0;
      disp_dots <= '0;
      pending <= 1'b0;
      digit <= '0;
      dot <= 1'b0;
      select <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      if (tick) idx <= boundary ? '0 : idx + IW'(1);
      if (load) begin
        shadow <= value_in;
        shadow_dots <= dots_in;
      end
      if (boundary && pending) begin
        disp <= shadow;
        disp_dots <= shadow_dots;
      end
      pending <= load | (pending & ~boundary);
      digit <= disp[DIGIT_W*idx +: DIGIT_W];
      dot <= disp_dots[idx];
      select <= (enable && !blanked[idx] && cnt != '0) ? (ACTIVE_LOW_SELECT != 0 ? ~onehot : onehot) : SEL_OFF;
      frame_done <= boundary;
    end
endmodule

// File: tb/tb_sev_seg_scanner.sv
// tb_sev_seg_scanner: directed and random scan stimulus checked against a time-arithmetic reference model.
module tb_sev_seg_scanner;
  logic clk = 0, rst = 1;
  logic [15:0] value_in = '0;
  logic [3:0] dots_in = '0;
  logic load = 0, enable = 0, blank_leading = 0;
  logic [3:0] digit, select;
  logic dot, pending, frame_done;
  int vecs = 0, errs = 0, t = 0;
  logic [15:0] msh = '0, mdisp = '0;
  logic [3:0] msd = '0, mdd = '0;
  logic mpend = 0;

  always #5 clk = ~clk;

  sev_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SELECT(1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dots_in(dots_in), .load(load),
    .enable(enable), .blank_leading(blank_leading), .digit(digit), .dot(dot),
    .select(select), .pending(pending), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; msh = '0; mdisp = '0; msd = '0; mdd = '0; mpend = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 16'(select), 16'hF);
    chk({tag, "_digit"}, 16'(digit), 16'h0);
    chk({tag, "_dot"}, 16'(dot), 16'h0);
    chk({tag, "_pend"}, 16'(pending), 16'h0);
    chk({tag, "_fd"}, 16'(frame_done), 16'h0);
  endtask

  // One clock: model predicts outputs from slot/phase arithmetic on the cycle count.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
    int s, ph;
    logic bnd, blk, edot;
    logic [3:0] ed, es;
    load = ld; value_in = v; dots_in = d;
    s = (t / 4) % 4;
    ph = t % 4;
    bnd = (t % 16) == 15;
    ed = 4'(mdisp >> (4 * s));
    edot = mdd[s];
    blk = s > 0 && blank_leading && (mdisp >> (4 * s)) == 16'h0;
    es = (enable && !blk && ph != 0) ? ~(4'b0001 << s) : 4'hF;
    if (bnd && mpend) begin mdisp = msh; mdd = msd; end
    if (ld) begin msh = v; msd = d; mpend = 1; end
    else if (bnd) mpend = 0;
    t++;
    @(posedge clk);
    #1;
    load = 0;
    chk("digit", 16'(digit), 16'(ed));
    chk("dot", 16'(dot), 16'(edot));
    chk("select", 16'(select), 16'(es));
    chk("pending", 16'(pending), 16'(mpend));
    chk("frame_done", 16'(frame_done), 16'(bnd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'($urandom), 4'($urandom));
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < 32 && (t % 16) != ph; i++) step(0, 16'($urandom), 4'($urandom));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 0;
    model_reset();
    enable = 1;
    idle(36);
    run_to(6);
    step(1, 16'h1234, 4'h0);
    idle(40);
    step(1, 16'h9999, 4'h0);
    idle(30);
    run_to(3);
    step(1, 16'h1234, 4'h0);
    run_to(15);
    step(1, 16'hABCD, 4'h0);
    idle(36);
    blank_leading = 1;
    step(1, 16'h0050, 4'h0);
    idle(40);
    step(1, 16'h0000, 4'h0);
    idle(40);
    blank_leading = 0;
    enable = 0;
    step(1, 16'h0000, 4'b0100);
    idle(40);
    enable = 1;
    idle(36);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 15) == 0) blank_leading = ~blank_leading;
      if ($urandom_range(0, 3) == 0)
        step(1, 16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF), 4'($urandom));
      else
        step(0, 16'($urandom), 4'($urandom));
    end
    enable = 1;
    run_to(1);
    step(1, 16'h8765, 4'hF);
    run_to(9);
    rst = 1;
    #1;
    chk_reset("rst_async");
    @(posedge clk);
    #1;
    chk_reset("rst_hold");
    rst = 0;
    model_reset();
    idle(40);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
